// File: rtl/lcd_line_scheduler.sv
// Per-scanline arbiter for the LCD line FIFO write port.
// Sequences one active line of bytes from host or pattern source.
module lcd_line_scheduler #(
  parameter int          LINE_BYTES = 1600,
  parameter int          STALL_MAX  = 64,
  parameter logic [7:0]  PAD_BYTE   = 8'h00
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        HSYNC,
  input  logic        VSYNC,
  input  logic [1:0]  mode,
  input  logic        host_valid,
  input  logic [7:0]  host_data,
  output logic        host_ready,
  input  logic        pat_valid,
  input  logic [7:0]  pat_data,
  output logic        pat_ready,
  input  logic        fifo_afull,
  output logic        FIFOWe,
  output logic [7:0]  RGBData,
  output logic [10:0] line_cnt,
  output logic        line_err,
  output logic        busy
);

  localparam int          SW = $clog2(STALL_MAX + 1);
  localparam logic [10:0] LB = 11'(LINE_BYTES);
  localparam logic [SW-1:0] SM = SW'(STALL_MAX);

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    XFER,
    PAD,
    DONE
  } state_t;

  state_t        state, state_nx;
  logic          src_pat, src_pat_nx;
  logic [10:0]   byte_cnt, byte_nx;
  logic [SW-1:0] stall_cnt, stall_nx;
  logic          hsync_q;
  logic          rr_toggle;
  logic          wr_nx;
  logic [7:0]    data_nx;
  logic          err_nx;
  logic          done;
  logic          line_start;
  logic          sync_any;
  logic          rdy;

  assign line_start = hsync_q & ~HSYNC & ~VSYNC;
  assign sync_any   = HSYNC | VSYNC;
  assign rdy        = ~fifo_afull;
  assign busy       = (state == ARB) || (state == XFER) || (state == PAD);

  // Next-state, handshake and write-pipeline decode
  always_comb begin
    state_nx   = state;
    src_pat_nx = src_pat;
    byte_nx    = byte_cnt;
    stall_nx   = stall_cnt;
    host_ready = 1'b0;
    pat_ready  = 1'b0;
    wr_nx      = 1'b0;
    data_nx    = RGBData;
    err_nx     = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (line_start) state_nx = ARB;
      end
      ARB: begin
        if (sync_any) begin
          state_nx = IDLE;
          err_nx   = 1'b1;
        end else begin
          case (mode)
            2'b00:   src_pat_nx = 1'b0;
            2'b01:   src_pat_nx = 1'b1;
            2'b10:   src_pat_nx = rr_toggle;
            default: src_pat_nx = ~host_valid;
          endcase
          byte_nx  = '0;
          stall_nx = '0;
          state_nx = XFER;
        end
      end
      XFER: begin
        if (sync_any) begin
          state_nx = IDLE;
          err_nx   = 1'b1;
        end else begin
          host_ready = rdy & ~src_pat;
          pat_ready  = rdy & src_pat;
          if ((host_ready & host_valid) | (pat_ready & pat_valid)) begin
            wr_nx    = 1'b1;
            data_nx  = src_pat ? pat_data : host_data;
            byte_nx  = byte_cnt + 11'd1;
            stall_nx = '0;
            if (byte_cnt + 11'd1 == LB) state_nx = DONE;
          end else if (host_ready) begin
            stall_nx = stall_cnt + 1'b1;
            if (stall_cnt + 1'b1 == SM) state_nx = PAD;
          end
        end
      end
      PAD: begin
        if (sync_any) begin
          state_nx = IDLE;
          err_nx   = 1'b1;
        end else if (rdy) begin
          wr_nx   = 1'b1;
          data_nx = PAD_BYTE;
          byte_nx = byte_cnt + 11'd1;
          if (byte_cnt + 11'd1 == LB) state_nx = DONE;
        end
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State, counters and registered FIFO write port
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      src_pat   <= 1'b0;
      byte_cnt  <= '0;
      stall_cnt <= '0;
      hsync_q   <= 1'b0;
      FIFOWe    <= 1'b0;
      RGBData   <= 8'h00;
      line_err  <= 1'b0;
    end else begin
      state     <= state_nx;
      src_pat   <= src_pat_nx;
      byte_cnt  <= byte_nx;
      stall_cnt <= stall_nx;
      hsync_q   <= HSYNC;
      FIFOWe    <= wr_nx;
      RGBData   <= data_nx;
      line_err  <= err_nx;
    end
  end

  // Completed-line count and round-robin bit, cleared by frame blanking
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      line_cnt  <= '0;
      rr_toggle <= 1'b0;
    end else if (VSYNC) begin
      line_cnt  <= '0;
      rr_toggle <= 1'b0;
    end else if (done) begin
      if (line_cnt != 11'd2047) line_cnt <= line_cnt + 11'd1;
      rr_toggle <= ~rr_toggle;
    end
  end

endmodule

// File: tb/tb_lcd_line_scheduler.sv
// Scoreboard bench for lcd_line_scheduler.
// Directed lines push expected bytes; a monitor pops on each FIFOWe.
`timescale 1ns/1ps
module tb_lcd_line_scheduler;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        HSYNC = 1'b0;
  logic        VSYNC = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic        host_valid;
  logic [7:0]  host_data;
  logic        host_ready;
  logic        pat_valid;
  logic [7:0]  pat_data;
  logic        pat_ready;
  logic        fifo_afull = 1'b0;
  logic        FIFOWe;
  logic [7:0]  RGBData;
  logic [10:0] line_cnt;
  logic        line_err;
  logic        busy;

  lcd_line_scheduler dut (
    .CLK(CLK), .RST(RST), .HSYNC(HSYNC), .VSYNC(VSYNC),
    .mode(mode),
    .host_valid(host_valid), .host_data(host_data),
    .host_ready(host_ready),
    .pat_valid(pat_valid), .pat_data(pat_data),
    .pat_ready(pat_ready),
    .fifo_afull(fifo_afull),
    .FIFOWe(FIFOWe), .RGBData(RGBData),
    .line_cnt(line_cnt), .line_err(line_err), .busy(busy)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Byte sources: host k -> k[7:0], pattern k -> ~k[7:0]
  int hidx = 0;
  int pidx = 0;
  int host_limit = 0;
  bit pat_en = 1'b0;
  bit src_clr = 1'b0;
  logic [7:0] hbyte, pbyte;
  assign hbyte      = hidx[7:0];
  assign pbyte      = pidx[7:0];
  assign host_valid = (hidx < host_limit);
  assign host_data  = hbyte;
  assign pat_valid  = pat_en;
  assign pat_data   = ~pbyte;

  always @(posedge CLK) begin
    if (src_clr) begin
      hidx <= 0;
      pidx <= 0;
    end else begin
      if (host_valid && host_ready) hidx <= hidx + 1;
      if (pat_valid && pat_ready) pidx <= pidx + 1;
    end
  end

  bit afull_en = 1'b0;
  int acnt = 0;
  always @(posedge CLK) begin
    if (afull_en) begin
      acnt <= acnt + 1;
      fifo_afull <= (acnt % 3 == 2);
    end else begin
      acnt <= 0;
      fifo_afull <= 1'b0;
    end
  end

  logic [7:0] exp_q[$];

  int m_chk = 0;
  int m_fail = 0;
  int wr_cnt = 0;
  int err_cnt = 0;
  int pad_bad = 0;
  int wr_cyc[$];
  bit pad_win = 1'b0;
  int pad_base = 0;
  logic prev_afull = 1'b0;

  // Monitor: pops the scoreboard on each write strobe
  always @(negedge CLK) begin
    logic [7:0] e;
    if (line_err) err_cnt++;
    if (FIFOWe) begin
      wr_cnt++;
      wr_cyc.push_back(cyc);
      m_chk++;
      if (exp_q.size() == 0) begin
        m_fail++;
        $display("FAIL unexpected_write: data %02h, none required", RGBData);
      end else begin
        e = exp_q.pop_front();
        if (RGBData !== e) begin
          m_fail++;
          $display("FAIL wr_data #%0d: got %02h required %02h",
                   wr_cnt, RGBData, e);
        end
      end
      m_chk++;
      if (prev_afull) begin
        m_fail++;
        $display("FAIL wr_after_afull: got write, required none");
      end
    end
    if (pad_win && busy && (wr_cnt - pad_base) > 100 && host_ready)
      pad_bad++;
    prev_afull = fifo_afull;
  end

  int n_chk = 0;
  int n_fail = 0;
  int fall_cyc = 0;

  task automatic tick(int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic check(string nm, int act, int req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", nm, act, req);
    end
  endtask

  task automatic push_host(int n);
    for (int k = 0; k < n; k++) exp_q.push_back(8'(k));
  endtask

  task automatic push_pat(int n);
    for (int k = 0; k < n; k++) exp_q.push_back(~8'(k));
  endtask

  task automatic push_pad(int n);
    for (int k = 0; k < n; k++) exp_q.push_back(8'h00);
  endtask

  task automatic start_line();
    HSYNC = 1'b1;
    tick(1);
    src_clr = 1'b1;
    tick(1);
    src_clr = 1'b0;
    HSYNC = 1'b0;
    fall_cyc = cyc;
  endtask

  task automatic wait_idle(string nm);
    int t = 0;
    while ((exp_q.size() != 0 || busy) && t < 5000) begin
      tick(1);
      t++;
    end
    check(nm, (t >= 5000) ? 1 : 0, 0);
    tick(3);
  endtask

  task automatic vsync_pulse();
    VSYNC = 1'b1;
    tick(2);
    VSYNC = 1'b0;
    tick(1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int wb, eb, t;
    host_limit = 0;
    pat_en = 1'b1;
    tick(3);
    check("rst_FIFOWe", FIFOWe, 0);
    check("rst_RGBData", RGBData, 0);
    check("rst_host_ready", host_ready, 0);
    check("rst_pat_ready", pat_ready, 0);
    check("rst_line_cnt", line_cnt, 0);
    check("rst_line_err", line_err, 0);
    check("rst_busy", busy, 0);
    RST = 1'b0;
    tick(2);

    // Mode 00 full host line
    mode = 2'b00;
    host_limit = 100000;
    wb = wr_cnt;
    eb = err_cnt;
    push_host(1600);
    start_line();
    wait_idle("t1_drain");
    check("t1_wr_count", wr_cnt - wb, 1600);
    check("t1_first_lat", wr_cyc[wb] - fall_cyc, 3);
    check("t1_span", wr_cyc[wb + 1599] - wr_cyc[wb], 1599);
    check("t1_line_cnt", line_cnt, 1);
    check("t1_line_err", err_cnt - eb, 0);

    // Host starves after 100 bytes: stall then pad
    host_limit = 100;
    wb = wr_cnt;
    pad_base = wr_cnt;
    pad_win = 1'b1;
    push_host(100);
    push_pad(1500);
    start_line();
    wait_idle("t2_drain");
    pad_win = 1'b0;
    check("t2_wr_count", wr_cnt - wb, 1600);
    check("t2_stall_gap", wr_cyc[wb + 100] - wr_cyc[wb + 99], 65);
    check("t2_pad_host_ready", pad_bad, 0);
    check("t2_line_cnt", line_cnt, 2);

    // Backpressure every third cycle
    host_limit = 100000;
    afull_en = 1'b1;
    wb = wr_cnt;
    push_host(1600);
    start_line();
    wait_idle("t3_drain");
    afull_en = 1'b0;
    check("t3_wr_count", wr_cnt - wb, 1600);
    check("t3_host_taken", hidx, 1600);
    check("t3_line_cnt", line_cnt, 3);

    // HSYNC mid-line abort after 500 bytes
    host_limit = 500;
    wb = wr_cnt;
    eb = err_cnt;
    push_host(500);
    start_line();
    t = 0;
    while (hidx < 500 && t < 2000) begin
      tick(1);
      t++;
    end
    check("t4_reach500", (t >= 2000) ? 1 : 0, 0);
    tick(5);
    HSYNC = 1'b1;
    tick(3);
    check("t4_line_err", err_cnt - eb, 1);
    check("t4_wr_count", wr_cnt - wb, 500);
    check("t4_q_empty", exp_q.size(), 0);
    check("t4_line_cnt", line_cnt, 3);
    check("t4_busy", busy, 0);
    host_limit = 100000;
    wb = wr_cnt;
    push_host(1600);
    start_line();
    wait_idle("t4b_drain");
    check("t4b_wr_count", wr_cnt - wb, 1600);
    check("t4b_first_lat", wr_cyc[wb] - fall_cyc, 3);
    check("t4b_line_cnt", line_cnt, 4);

    // Alternate per line after frame clear
    vsync_pulse();
    check("t5_vsync_clr", line_cnt, 0);
    mode = 2'b10;
    for (int ln = 0; ln < 4; ln++) begin
      wb = wr_cnt;
      if (ln % 2 == 0) push_host(1600);
      else push_pat(1600);
      start_line();
      wait_idle("t5_drain");
      check("t5_wr_count", wr_cnt - wb, 1600);
    end
    check("t5_line_cnt", line_cnt, 4);
    vsync_pulse();
    check("t5_vsync_clr2", line_cnt, 0);

    // Mode 11, host absent at arbitration
    mode = 2'b11;
    host_limit = 0;
    wb = wr_cnt;
    push_pat(1600);
    start_line();
    tick(20);
    host_limit = 100000;
    wait_idle("t6_drain");
    check("t6_wr_count", wr_cnt - wb, 1600);
    check("t6_host_unused", hidx, 0);
    check("t6_line_cnt", line_cnt, 1);

    // Async reset mid-transfer
    mode = 2'b00;
    wb = wr_cnt;
    push_host(1600);
    start_line();
    t = 0;
    while ((wr_cnt - wb) < 200 && t < 2000) begin
      tick(1);
      t++;
    end
    check("t7_reach200", (t >= 2000) ? 1 : 0, 0);
    @(posedge CLK);
    #3;
    RST = 1'b1;
    #1;
    check("t7_FIFOWe", FIFOWe, 0);
    check("t7_RGBData", RGBData, 0);
    check("t7_host_ready", host_ready, 0);
    check("t7_busy", busy, 0);
    check("t7_line_cnt", line_cnt, 0);
    tick(2);
    RST = 1'b0;
    exp_q.delete();
    wb = wr_cnt;
    tick(5);
    check("t7_idle_no_wr", wr_cnt - wb, 0);
    check("t7_idle_ready", host_ready, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk + m_chk, n_fail + m_fail);
    $finish;
  end

endmodule

// File: doc/lcd_line_scheduler.md
Name: lcd_line_scheduler

Overview:
- Per-scanline scheduler and arbiter for the LCD FIFO write port. It shares that port between two requesters: the host pixel stream from the 8080 interface and the test-pattern source.
- It sequences exactly LINE_BYTES writes per active line and pads a line when the host starves. It aborts cleanly if a sync pulse arrives mid-line.
- It sits between the 8080 register/data front end and the line FIFO feeding RGB output.

Parameters:
LINE_BYTES, 1600, bytes written per active line (2 bytes/pixel x 800)
STALL_MAX, 64, consecutive starved cycles on the host source before padding
PAD_BYTE, 8'h00, fill value used in PAD state

Ports:
CLK  input  1  system clock
RST  input  1  asynchronous active-high reset
HSYNC  input  1  line blanking, active-high
VSYNC  input  1  frame blanking, active-high
mode  input  2  00 host only, 01 pattern only, 10 alternate per line, 11 host priority with pattern fallback
host_valid  input  1  host byte available
host_data  input  8  host byte
host_ready  output  1  host byte accepted when valid&ready
pat_valid  input  1  pattern byte available
pat_data  input  8  pattern byte
pat_ready  output  1  pattern byte accepted when valid&ready
fifo_afull  input  1  FIFO almost-full (asserted with at least 1 free entry remaining)
FIFOWe  output  1  FIFO write strobe, registered
RGBData  output  8  FIFO write data, registered
line_cnt  output  11  completed lines in current frame
line_err  output  1  one-cycle pulse on aborted line
busy  output  1  high in ARB/XFER/PAD

Behaviour:
- Reset (RST high, async): state IDLE. FIFOWe=0, RGBData=0, host_ready=0, pat_ready=0, line_cnt=0, line_err=0, rr_toggle=0, byte_cnt=0, stall_cnt=0.
- Line start: registered HSYNC falling edge (HSYNC 1->0) while VSYNC=0.
- States:
  - IDLE: on line start -> ARB.
  - ARB (1 cycle): latch src. Mode 00 -> host. 01 -> pattern. 10 -> host if rr_toggle=0, else pattern. 11 -> host if host_valid=1 this cycle, else pattern. Then -> XFER with byte_cnt=0, stall_cnt=0.
  - XFER: selected ready = !fifo_afull; the other ready = 0. On valid&ready: byte_cnt+1, and next cycle FIFOWe=1 with RGBData=data (1-cycle latency). With host selected, a cycle with ready=1 & valid=0 increments stall_cnt; any transfer clears it. stall_cnt reaching STALL_MAX -> PAD. byte_cnt reaching LINE_BYTES -> DONE.
  - PAD: both readies 0. Each cycle with !fifo_afull writes PAD_BYTE (FIFOWe next cycle) and byte_cnt+1. byte_cnt = LINE_BYTES -> DONE.
  - DONE (1 cycle): line_cnt+1 (saturates at 2047), rr_toggle inverts -> IDLE.
- Backpressure: fifo_afull stops acceptance in the same cycle (ready is combinational on fifo_afull). No write ever occurs while fifo_afull=1 was sampled at acceptance. fifo_afull does not count as a stall.
- Abort: HSYNC=1 or VSYNC=1 while in ARB/XFER/PAD -> IDLE next cycle and line_err pulses 1 cycle. An in-flight registered write still completes. line_cnt is not incremented and rr_toggle is unchanged.
- VSYNC=1 in any state: line_cnt cleared to 0 and rr_toggle cleared to 0. A line start is not recognised while VSYNC=1.
- Simultaneous events: abort has priority over completion. If the last byte and HSYNC rise occur in the same cycle, the line counts as completed (byte_cnt reached LINE_BYTES) only if the last transfer happened in the prior cycle; otherwise it is an abort.
- Width rules: byte_cnt is 11 bits and stall_cnt is $clog2(STALL_MAX+1) bits; neither wraps because the transitions trigger at the limits.
- Mode change mid-line has no effect until the next ARB.

Test Plan:
- Mode 00, host_valid=1 continuously, fifo_afull=0, one HSYNC pulse -> 1600 consecutive FIFOWe cycles starting 3 cycles after HSYNC falls, data equals host stream, line_cnt=1, line_err=0.
- Mode 10, 4 lines, both sources valid -> lines 0 and 2 carry host data, lines 1 and 3 carry pattern data; line_cnt=4; VSYNC pulse -> line_cnt=0.
- Mode 00, host supplies 100 bytes then valid=0 -> after 64 stall cycles, 1500 writes of 8'h00 follow; total FIFOWe count 1600; host_ready=0 during PAD.
- fifo_afull toggled 1 every 3rd cycle during XFER -> no accept on those cycles, no data lost or duplicated, total 1600 writes, stall_cnt stays 0.
- HSYNC asserted after 500 bytes -> line_err pulses once, at most 1 trailing FIFOWe, line_cnt unchanged, next line starts cleanly with byte_cnt=0.
- Mode 11 with host_valid=0 at ARB -> pattern selected for whole line even if host_valid rises mid-line; RST asserted mid-XFER -> all outputs 0 immediately, state IDLE.
